rr_deadline_arb: RTL
====================

// Module: rr_deadline_arb
// PURPOSE
//  Round-robin scheduler that shares one service slot among N pulse requesters.
//  Guarantees a bounded response: every request is acked 1..N cycles later.
//  For N=2 this is the contract a |-> ##[1:2] b.
//  Sits between stimulus/request sources and a single-issue resource.
//  Carries its own SVA, clocked on posedge clock with disable iff (reset).
// PARAMETERS
//  N    4           number of requesters, 2..16
//  IW   $clog2(N)   width of ack_id (derived, do not override)
//  LW   $clog2(N+1) width of ack_lat (derived, do not override)
// PORTS
//  clock    in   1   single clock, all state on posedge
//  reset    in   1   synchronous, active-high
//  req      in   N   req[i] high at an edge = one request from i
//  ack      out  N   registered, zero- or one-hot; ack[i] = request i served
//  ack_id   out  IW  index of the asserted ack bit; 0 when ack==0
//  ack_lat  out  LW  edges from sampled req to ack, 1..N; 0 when ack==0
//  overrun  out  N   1-cycle pulse: req[i] while i already pending (merged)
//  busy     out  1   registered; any request pending after this edge
// BEHAVIOUR
//  Reset (sampled high at an edge):
//   - clears pending, age, ptr, ack, ack_id, ack_lat, overrun, busy.
//   - req on the same edge is ignored.
//   - requests pending at a mid-operation reset are dropped, never acked.
//  State:
//   - pending[N]: one flag per requester.
//   - age[i] (LW bits): edges since req[i] was captured.
//   - ptr (IW bits): round-robin start index.
//  Candidates at each edge: cand = pending_q | req.
//  Winner: first set bit of cand scanning ptr, ptr+1, ... modulo N.
//   - Wrap-around from N-1 to 0 is required.
//  If cand != 0:
//   - ack_q <= onehot(w); ack_id <= w.
//   - ack_lat <= 1 if w is newly requested this edge, else age[w]+1.
//   - pending[w] <= 0; ptr <= (w+1) mod N.
//  If cand == 0: ack, ack_id, ack_lat <= 0; ptr holds.
//  Capture: req[i] with pending_q[i]==0 and i not winner:
//   - pending[i] <= 1; age[i] <= 1.
//  Aging: pending non-winner i: age[i] <= age[i]+1. age never exceeds N-1.
//  Merge: req[i] with pending_q[i]==1:
//   - overrun[i] <= 1 for one cycle.
//   - no second ack; age keeps the older request.
//   - This applies even when i wins this edge: the new pulse is absorbed.
//  busy <= |(pending next-state).
//  Latency: req sampled at edge k -> ack[i] sampled high at exactly one edge in k+1..k+N.
//   - Best case k+1: sole candidate.
//   - Worst case k+N: all N requesting with ptr just past i.
//  Simultaneous events:
//   - ack_q[i] high and req[i] at the same edge is a NEW request; it is captured.
//   - At most one ack per cycle, ever.
//  Width: age/ack_lat saturate at N by construction. Add no saturating logic;
//   an assertion checks it.
//  Built-in SVA (disable iff reset):
//   - req[i] && !pending_q[i] |-> ##[1:N] ack[i]
//   - $onehot0(ack)
//   - ack!=0 |-> ack_lat inside {[1:N]}
//   - ack[i] |-> !pending_q[i] at next edge unless req[i] re-captured
// TESTING (N=4 unless stated; edge indices from first edge after reset release)
//  1. Single req[2] at edge 3
//      -> ack=4'b0100 at edge 4, ack_id=2, ack_lat=1, busy=0 at edge 4.
//  2. req=4'b1111 at edge 2, ptr=0
//      -> acks 0,1,2,3 at edges 3,4,5,6; ack_lat 1,2,3,4; busy low after edge 6.
//  3. Wrap-around: ptr=3, req=4'b1001 at edge 5
//      -> ack id 3 at edge 6, id 0 at edge 7 (lat 2).
//  4. req[1] at edges 2 and 3 while 0,2,3 also pending
//      -> overrun[1] pulse at edge 4; exactly one ack[1], lat <= 4.
//  5. N=2 replay of r="-_____-_______________", req0="_-____-_______-_______"
//      -> ack0 at edges 2 and 15; edge-6 req dropped by reset; no SVA failure.
//  6. Reset high at edge 4 with 3 pending -> all outputs 0 at edge 5; no stale ack afterward.

Source files
------------

// File: rtl/rr_deadline_arb_if.sv
// Request/ack bundle between pulse requesters and the round-robin deadline arbiter.
// master drives req and observes the service outputs; slave is the arbiter.
interface rr_deadline_arb_if #(parameter int N = 4);
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic [IW-1:0] ack_id;
    logic [LW-1:0] ack_lat;
    logic [N-1:0]  overrun;
    logic          busy;

    modport master (output req, input ack, ack_id, ack_lat, overrun, busy);
    modport slave  (input req, output ack, ack_id, ack_lat, overrun, busy);
endinterface

// File: rtl/rr_deadline_arb.sv
// Round-robin arbiter sharing one service slot among N pulse requesters.
// Latency 1..N edges from sampled req to ack; no backpressure, repeat reqs merge.
module rr_deadline_arb #(
    parameter int N = 4
) (
    input  logic            clock,
    input  logic            reset,
    rr_deadline_arb_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    logic [N-1:0]  pending_q, pending_d;
    logic [LW-1:0] age_q [N];
    logic [LW-1:0] age_d [N];
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [IW-1:0] ack_id_q, ack_id_d;
    logic [LW-1:0] ack_lat_q, ack_lat_d;
    logic [N-1:0]  overrun_q, overrun_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  cand;
    logic          win_vld;
    logic [IW-1:0] win;
    logic [IW:0]   slot;

    always_comb begin
        cand    = pending_q | bus.req;
        win_vld = 1'b0;
        win     = '0;
        slot    = '0;
        // Scan from ptr upward, wrapping past N-1 back to 0.
        for (int k = 0; k < N; k++) begin
            slot = {1'b0, ptr_q} + (IW+1)'(k);
            if (slot >= (IW+1)'(N)) slot = slot - (IW+1)'(N);
            if (!win_vld && cand[IW'(slot)]) begin
                win_vld = 1'b1;
                win     = IW'(slot);
            end
        end
    end

    always_comb begin
        pending_d = '0;
        age_d     = age_q;
        ack_d     = '0;
        ack_id_d  = '0;
        ack_lat_d = '0;
        ptr_d     = ptr_q;
        overrun_d = bus.req & pending_q;

        for (int i = 0; i < N; i++) begin
            if (win_vld && win == IW'(i)) begin
                pending_d[i] = 1'b0;
                age_d[i]     = '0;
            end else if (pending_q[i]) begin
                pending_d[i] = 1'b1;
                age_d[i]     = age_q[i] + LW'(1);
            end else if (bus.req[i]) begin
                pending_d[i] = 1'b1;
                age_d[i]     = LW'(1);
            end else begin
                pending_d[i] = 1'b0;
                age_d[i]     = '0;
            end
        end

        if (win_vld) begin
            ack_d[win] = 1'b1;
            ack_id_d   = win;
            // A winner that was not already waiting is served on its own edge.
            ack_lat_d  = pending_q[win] ? age_q[win] + LW'(1) : LW'(1);
            ptr_d      = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        end

        busy_d = |pending_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            ack_id_q  <= '0;
            ack_lat_q <= '0;
            overrun_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N; i++) age_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            ack_id_q  <= ack_id_d;
            ack_lat_q <= ack_lat_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
        end
    end

    assign bus.ack     = ack_q;
    assign bus.ack_id  = ack_id_q;
    assign bus.ack_lat = ack_lat_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = busy_q;

    a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(ack_q));
    a_lat:    assert property (@(posedge clock) disable iff (reset)
                  ack_q != '0 |-> (ack_lat_q >= LW'(1) && ack_lat_q <= LW'(N)));

    // Served-or-captured on the next edge plus the age ceiling together bound response to N edges.
    for (genvar g = 0; g < N; g++) begin : g_sva
        a_capture: assert property (@(posedge clock) disable iff (reset)
                       bus.req[g] && !pending_q[g] |=> ack_q[g] || pending_q[g]);
        a_age:     assert property (@(posedge clock) disable iff (reset)
                       pending_q[g] |-> (age_q[g] >= LW'(1) && age_q[g] <= LW'(N - 1)));
        a_release: assert property (@(posedge clock) disable iff (reset)
                       ack_q[g] && !bus.req[g] |=> !pending_q[g]);
    end
endmodule
